// File: rtl/rram_cmd_issuer.sv
// Host-side initiator for the RRAM chip command interface: sequences CE/CLE/ALE,
// the opcode bus and the address bus for one read, write or forming request at a time.
module rram_cmd_issuer #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CMD_CYC  = 2,
  parameter int unsigned ADDR_CYC = 2,
  parameter int unsigned EXEC_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              CE,
  output logic              CLE,
  output logic              ALE,
  output logic [3:0]        command,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CE_SETUP = 3'd1;
  localparam logic [2:0] S_CMD1     = 3'd2;
  localparam logic [2:0] S_CMD2     = 3'd3;
  localparam logic [2:0] S_ADDR     = 3'd4;
  localparam logic [2:0] S_EXEC     = 3'd5;
  localparam logic [2:0] S_RELEASE  = 3'd6;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_FORM = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam logic [3:0] C_NOP  = 4'b0000;
  localparam logic [3:0] C_READ = 4'b0001;
  localparam logic [3:0] C_WR1  = 4'b0100;
  localparam logic [3:0] C_WR2  = 4'b0010;
  localparam logic [3:0] C_FM1  = 4'b0111;
  localparam logic [3:0] C_FM2  = 4'b0110;

  // Counter preload values: phase length minus one, exit when the counter reads zero.
  localparam logic [CNT_W-1:0] CMD_LD  = CNT_W'(CMD_CYC - 1);
  localparam logic [CNT_W-1:0] ADDR_LD = CNT_W'(ADDR_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD = CNT_W'(EXEC_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              req_ready_d, ce_d, cle_d, ale_d, busy_d, done_d, err_d;
  logic [3:0]        command_d;
  logic [ADDR_W-1:0] addr_out_d;
  logic [3:0]        first_cmd, second_cmd, last_cmd;

  // Next-state, counter and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d   = req_op;
          addr_d = req_addr;
          cnt_d  = '0;
          state_d = (req_op == OP_RSVD) ? S_RELEASE : S_CE_SETUP;
        end
      end
      S_CE_SETUP: begin
        state_d = S_CMD1;
        cnt_d   = CMD_LD;
      end
      S_CMD1: begin
        if (cnt_q == '0) begin
          if (op_q == OP_READ) begin
            state_d = S_ADDR;
            cnt_d   = ADDR_LD;
          end else begin
            state_d = S_CMD2;
            cnt_d   = CMD_LD;
          end
        end
      end
      S_CMD2: begin
        if (cnt_q == '0) begin
          state_d = S_ADDR;
          cnt_d   = ADDR_LD;
        end
      end
      S_ADDR: begin
        if (cnt_q == '0) begin
          state_d = S_EXEC;
          cnt_d   = EXEC_LD;
        end
      end
      S_EXEC: begin
        if (cnt_q == '0) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Opcode selection for the latched request.
  always_comb begin
    first_cmd  = C_NOP;
    second_cmd = C_NOP;
    case (op_d)
      OP_READ: first_cmd = C_READ;
      OP_WR: begin
        first_cmd  = C_WR1;
        second_cmd = C_WR2;
      end
      OP_FORM: begin
        first_cmd  = C_FM1;
        second_cmd = C_FM2;
      end
      default: begin
        first_cmd  = C_NOP;
        second_cmd = C_NOP;
      end
    endcase
    last_cmd = (op_d == OP_READ) ? first_cmd : second_cmd;
  end

  // Pin values decoded from the next state so every output leaves a flop.
  always_comb begin
    req_ready_d = 1'b0;
    busy_d      = 1'b1;
    ce_d        = 1'b0;
    cle_d       = 1'b0;
    ale_d       = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    command_d   = C_NOP;
    addr_out_d  = addr_out;
    case (state_d)
      S_IDLE: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        ce_d        = 1'b1;
      end
      S_CE_SETUP: command_d = C_NOP;
      S_CMD1: begin
        cle_d     = 1'b1;
        command_d = first_cmd;
      end
      S_CMD2: begin
        cle_d     = 1'b1;
        command_d = second_cmd;
      end
      S_ADDR: begin
        ale_d      = 1'b1;
        command_d  = last_cmd;
        addr_out_d = addr_d;
      end
      S_EXEC: command_d = last_cmd;
      S_RELEASE: begin
        ce_d   = 1'b1;
        done_d = 1'b1;
        err_d  = (op_d == OP_RSVD);
      end
      default: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        ce_d        = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_READ;
      addr_q    <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      CE        <= 1'b1;
      CLE       <= 1'b0;
      ALE       <= 1'b0;
      command   <= C_NOP;
      addr_out  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      CE        <= ce_d;
      CLE       <= cle_d;
      ALE       <= ale_d;
      command   <= command_d;
      addr_out  <= addr_out_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  // Latch enables must never overlap on the pins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(CLE && ALE)) else $error("CLE and ALE high together");
    end
  end

endmodule

// File: doc/rram_cmd_issuer.md
# rram_cmd_issuer

Host-side initiator for the RRAM array's chip command interface. Accepts one read, write or forming request at a time and sequences CE, CLE, ALE, the 4-bit command bus and the address bus so that the array-side command state register decodes the intended state. Sits between the host request logic and the RRAM chip pins; it is the driving end of the interface the array-side state register receives.

## Interface
- ADDR_W, 8, width of req_addr and addr_out
- CMD_CYC, 2, cycles each command opcode is held with CLE high (1..255)
- ADDR_CYC, 2, cycles the address is held with ALE high (1..255)
- EXEC_CYC, 4, cycles CE is held low after the address phase for the array to execute (1..255)

- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_op  input  2  00 read, 01 write, 10 forming, 11 reserved
- req_addr  input  ADDR_W  target address
- req_ready  output  1  high only in IDLE; request accepted on req_valid & req_ready
- CE  output  1  chip enable, active low (1 = deselected, array clears its state)
- CLE  output  1  command latch enable
- ALE  output  1  address latch enable
- command  output  4  opcode bus
- addr_out  output  ADDR_W  address bus
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of each accepted request
- err  output  1  one-cycle pulse, coincident with done, for reserved op

## Operation
- All outputs registered. Reset values: CE=1, CLE=0, ALE=0, command=4'b0000, addr_out=0, req_ready=1, busy=0, done=0, err=0; FSM=IDLE; counter=0.
- Opcodes: read = single unit 0001. Write = 0100 then 0010. Forming = 0111 then 0110.
- States: IDLE, CE_SETUP, CMD1, CMD2, ADDR, EXEC, RELEASE.
- IDLE: CE=1, CLE=0, ALE=0, command=0000. On accept, latch op and addr; reserved op -> RELEASE with err; else -> CE_SETUP.
- CE_SETUP (1 cycle): CE=0, command=0000, CLE=0.
- CMD1 (CMD_CYC cycles): CLE=1, command=first opcode. Read -> ADDR; write/forming -> CMD2.
- CMD2 (CMD_CYC cycles): CLE=1, command=second opcode. Transition from first to second opcode is direct, with no intermediate 0000 cycle; an intermediate value would hit the decoder default and clear its state.
- ADDR (ADDR_CYC cycles): CLE=0, ALE=1, addr_out=latched address, command holds last opcode.
- EXEC (EXEC_CYC cycles): ALE=0, CE=0, command and addr_out held.
- RELEASE (1 cycle): CE=1, command=0000, CLE=ALE=0, done=1 (err=1 if reserved). Next state IDLE.
- Counter is 8 bits, loaded with the phase length minus 1 on phase entry and decremented; phase exits when it reads 0.
- req_addr and req_op are sampled only at accept; changes afterwards are ignored.
- req_valid during busy is ignored. It is not queued, and the requester holds it until ready.

## Timing
- Accept edge = E0. Phase boundaries fall on subsequent edges.
- Read: CE low from E0+1. CLE high for cycles 2..1+CMD_CYC. ALE high for next ADDR_CYC cycles, then EXEC. done high in cycle 2+CMD_CYC+ADDR_CYC+EXEC_CYC after E0. With defaults, done is high in cycle 10 and req_ready returns in cycle 11.
- Write/forming: done high in cycle 2+2·CMD_CYC+ADDR_CYC+EXEC_CYC after E0. With defaults, this is cycle 12.
- Reserved op: done=err=1 in cycle 1 after E0. CE never leaves 1.
- CE never falls without a preceding IDLE. CLE and ALE are never simultaneously high.
- Back-to-back: the minimum gap between successive CE-low windows is 2 cycles (RELEASE + IDLE).
- Reset mid-operation: on the edge where rst=1, all outputs take reset values in the next cycle. CE=1 forces the array to state 0. No done pulse is issued.

## Test plan
- Reset then read addr 0x3C, defaults -> CE low cycles 1–9; command=0001 with CLE cycles 2–3; ALE with addr_out=0x3C cycles 4–5; done in cycle 10; req_ready high in cycle 11.
- Write addr 0xA5 -> command 0100 (cycles 2–3) immediately followed by 0010 (cycles 4–5), no 0000 between; ALE cycles 6–7; done in cycle 12.
- Forming addr 0x01 with CMD_CYC=1, ADDR_CYC=1, EXEC_CYC=1 -> 0111 in cycle 2, 0110 in cycle 3, ALE in cycle 4, EXEC in cycle 5, done in cycle 6.
- req_op=11 -> done=err=1 in cycle 1; CE, CLE and ALE stay idle throughout.
- rst asserted during CMD2 of a write -> next cycle CE=1, command=0000, busy=0, req_ready=1, no done; a following read completes normally.
- req_valid held high with changing req_addr during a read -> the address latched at accept is driven; second request accepted only in IDLE after done.
